// File: rtl/dec_entry_14b.sv
// Digit-serial BCD entry: each accepted digit is folded into a binary
// magnitude as acc*10 + d via two shift-add cycles; the result is held until acknowledged.
module dec_entry_14b #(
  parameter int NDIG = 4,
  parameter int W    = 14
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic [3:0]   dig,
  input  logic         dig_valid,
  output logic         dig_ready,
  input  logic         neg,
  input  logic         enter,
  input  logic         clear,
  input  logic         result_ack,
  output logic [W-1:0] value,
  output logic         sign,
  output logic [2:0]   digit_cnt,
  output logic         busy,
  output logic         result_valid,
  output logic         err
);

  typedef enum logic [1:0] {ENTRY, MUL, ADD, DONE} state_t;

  localparam logic [2:0] NDIG_C = 3'(NDIG);

  state_t         state_q, state_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [W+3:0]   tmp_q, tmp_d;
  logic [3:0]     digit_q, digit_d;
  logic [2:0]     cnt_q, cnt_d;
  logic           sign_q, sign_d;
  logic           err_q, err_d;
  logic           accept;

  // First half of the x10: acc*8 + digit, kept wide so nothing is lost.
  function automatic logic [W+3:0] mul8_add(input logic [W-1:0] a, input logic [3:0] d);
    return ({4'b0, a} << 3) + {{W{1'b0}}, d};
  endfunction

  // Second half: add acc*2; the parameter rule guarantees the sum fits in W bits.
  function automatic logic [W-1:0] add2_trunc(input logic [W+3:0] t, input logic [W-1:0] a);
    return W'(t + ({4'b0, a} << 1));
  endfunction

  assign dig_ready = (state_q == ENTRY) & ~enter & ~clear;
  assign accept    = dig_valid & dig_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    tmp_d   = tmp_q;
    digit_d = digit_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    err_d   = 1'b0;
    if (clear) begin
      state_d = ENTRY;
      acc_d   = '0;
      cnt_d   = '0;
      sign_d  = 1'b0;
    end else begin
      case (state_q)
        ENTRY: begin
          if (enter) begin
            // Toggle first, then suppress negative zero.
            sign_d  = (acc_q == '0) ? 1'b0 : (sign_q ^ neg);
            state_d = DONE;
          end else begin
            if (neg) sign_d = ~sign_q;
            if (accept) begin
              if (dig <= 4'd9 && cnt_q < NDIG_C) begin
                digit_d = dig;
                state_d = MUL;
              end else begin
                err_d = 1'b1;
              end
            end
          end
        end
        MUL: begin
          tmp_d   = mul8_add(acc_q, digit_q);
          state_d = ADD;
        end
        ADD: begin
          acc_d   = add2_trunc(tmp_q, acc_q);
          cnt_d   = cnt_q + 3'd1;
          state_d = ENTRY;
        end
        DONE: begin
          if (result_ack) begin
            acc_d   = '0;
            cnt_d   = '0;
            sign_d  = 1'b0;
            state_d = ENTRY;
          end
        end
        default: state_d = ENTRY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= ENTRY;
      acc_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      err_q   <= err_d;
    end
  end

  // Pure datapath holding registers; only meaningful while in MUL/ADD.
  always_ff @(posedge clk) begin
    tmp_q   <= tmp_d;
    digit_q <= digit_d;
  end

  assign value        = acc_q;
  assign sign         = sign_q;
  assign digit_cnt    = cnt_q;
  assign busy         = (state_q == MUL) | (state_q == ADD);
  assign result_valid = (state_q == DONE);
  assign err          = err_q;

endmodule

// File: tb/tb_dec_entry_14b.sv
// Bench for dec_entry_14b: directed vector table, hand-written corner sequences,
// and randomized traffic against a digit-level arithmetic model.
module tb_dec_entry_14b;
  logic        clk = 1'b0;
  logic        clr_n;
  logic [3:0]  dig;
  logic        dig_valid, dig_ready, neg, enter, clear, result_ack;
  logic [13:0] value;
  logic        sign, busy, result_valid, err;
  logic [2:0]  digit_cnt;

  always #5 clk = ~clk;

  dec_entry_14b #(.NDIG(4), .W(14)) dut (
    .clk(clk), .clr_n(clr_n), .dig(dig), .dig_valid(dig_valid),
    .dig_ready(dig_ready), .neg(neg), .enter(enter), .clear(clear),
    .result_ack(result_ack), .value(value), .sign(sign),
    .digit_cnt(digit_cnt), .busy(busy), .result_valid(result_valid), .err(err)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit dv; logic [3:0] d; bit ng; bit en; bit cl; bit ak;
    int val; bit sg; int cnt; bit rv; bit bsy; bit er;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit dv, int d, bit ng, bit en, bit cl, bit ak,
                              int val, bit sg, int cnt, bit rv, bit bsy, bit er);
    vec_t v;
    v = '{dv, 4'(d), ng, en, cl, ak, val, sg, cnt, rv, bsy, er};
    return v;
  endfunction

  // One full digit: accept cycle, MUL, ADD; expectations follow decimal arithmetic.
  task automatic add_digit(input int d, inout int val, inout int cnt, input bit sg);
    tbl.push_back(mk(1, d, 0, 0, 0, 0, val, sg, cnt, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, val, sg, cnt, 0, 1, 0));
    val = val * 10 + d;
    cnt++;
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, val, sg, cnt, 0, 0, 0));
  endtask

  task automatic drive(input bit dv, input int d, input bit ng, input bit en,
                       input bit cl, input bit ak);
    @(negedge clk);
    dig_valid = dv; dig = 4'(d); neg = ng; enter = en; clear = cl; result_ack = ak;
  endtask

  task automatic step(input bit dv, input int d, input bit ng, input bit en,
                      input bit cl, input bit ak);
    drive(dv, d, ng, en, cl, ak);
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string t, input int val, input bit sg, input int cnt,
                           input bit rv, input bit bsy, input bit er);
    chk({t, ".value"}, int'(value), val);
    chk({t, ".sign"}, int'(sign), int'(sg));
    chk({t, ".cnt"}, int'(digit_cnt), cnt);
    chk({t, ".rv"}, int'(result_valid), int'(rv));
    chk({t, ".busy"}, int'(busy), int'(bsy));
    chk({t, ".err"}, int'(err), int'(er));
  endtask

  // Reference model state: decimal accumulator plus a countdown for the in-flight digit.
  int m_acc, m_cnt, m_pend, m_pd;
  bit m_sg, m_done, m_err;

  task automatic model_zero();
    m_acc = 0; m_cnt = 0; m_pend = 0; m_sg = 0; m_done = 0; m_err = 0;
  endtask

  task automatic model_step(input bit dv, input int d, input bit ng, input bit en,
                            input bit cl, input bit ak);
    m_err = 0;
    if (cl) model_zero();
    else if (m_done) begin
      if (ak) model_zero();
    end else if (m_pend > 0) begin
      m_pend--;
      if (m_pend == 0) begin
        m_acc = m_acc * 10 + m_pd;
        m_cnt++;
      end
    end else if (en) begin
      if (ng) m_sg = !m_sg;
      if (m_acc == 0) m_sg = 0;
      m_done = 1;
    end else begin
      if (dv) begin
        if (d <= 9 && m_cnt < 4) begin m_pd = d; m_pend = 2; end
        else m_err = 1;
      end
      if (ng) m_sg = !m_sg;
    end
  endtask

  initial begin
    int v, c;
    clr_n = 1'b0; dig = '0; dig_valid = 0; neg = 0; enter = 0; clear = 0; result_ack = 0;
    #12;
    check_out("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    clr_n = 1'b1;
    #1;
    chk("reset.ready", int'(dig_ready), 1);

    // 1,2,3,4 enter, held result, digit ignored in DONE, ack
    v = 0; c = 0;
    add_digit(1, v, c, 0); add_digit(2, v, c, 0); add_digit(3, v, c, 0); add_digit(4, v, c, 0);
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1234, 0, 4, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1234, 0, 4, 1, 0, 0));
    tbl.push_back(mk(1, 9, 1, 0, 0, 0, 1234, 0, 4, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    // 7 then illegal 0xB
    v = 0; c = 0;
    add_digit(7, v, c, 0);
    tbl.push_back(mk(1, 11, 0, 0, 0, 0, 7, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 7, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    // neg, 4, 2, enter -> -42
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    v = 0; c = 0;
    add_digit(4, v, c, 1); add_digit(2, v, c, 1);
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 42, 1, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    // neg then enter with no digits, and neg+enter together: both give +0
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    // clear during MUL discards the digit
    v = 0; c = 0;
    add_digit(1, v, c, 0); add_digit(2, v, c, 0);
    tbl.push_back(mk(1, 3, 0, 0, 0, 0, 12, 0, 2, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    v = 0; c = 0;
    add_digit(5, v, c, 0);
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      step(tbl[i].dv, int'(tbl[i].d), tbl[i].ng, tbl[i].en, tbl[i].cl, tbl[i].ak);
      check_out($sformatf("vec%0d", i), tbl[i].val, tbl[i].sg, tbl[i].cnt,
                tbl[i].rv, tbl[i].bsy, tbl[i].er);
    end

    // 9999 then a fifth digit is rejected
    for (int i = 0; i < 4; i++) begin
      step(1, 9, 0, 0, 0, 0); step(0, 0, 0, 0, 0, 0); step(0, 0, 0, 0, 0, 0);
    end
    check_out("full", 9999, 0, 4, 0, 0, 0);
    step(1, 5, 0, 0, 0, 0);
    check_out("fifth", 9999, 0, 4, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    check_out("fifth_after", 9999, 0, 4, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    check_out("full_enter", 9999, 0, 4, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    check_out("full_ack", 0, 0, 0, 0, 0, 0);

    // dig_valid held with 6: one accept every third cycle
    for (int i = 0; i < 9; i++) begin
      drive(1, 6, 0, 0, 0, 0);
      #1;
      chk($sformatf("hold.ready%0d", i), int'(dig_ready), (i % 3 == 0) ? 1 : 0);
      @(posedge clk);
      #1;
      if (i % 3 == 2) chk($sformatf("hold.value%0d", i), int'(value), (i == 2) ? 6 : (i == 5) ? 66 : 666);
    end
    step(0, 0, 0, 0, 0, 0);
    check_out("hold_end", 666, 0, 3, 0, 0, 0);

    // async reset in the middle of ADD
    step(1, 7, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("pre_rst.busy", int'(busy), 1);
    clr_n = 1'b0;
    #1;
    check_out("async_rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    clr_n = 1'b1;
    #1;
    chk("async_rst.ready", int'(dig_ready), 1);
    step(0, 0, 0, 0, 0, 0);
    check_out("async_rst_after", 0, 0, 0, 0, 0, 0);

    // randomized traffic against the model
    model_zero();
    for (int i = 0; i < 3000; i++) begin
      bit dv, ng, en, cl, ak, rdy;
      int d;
      dv = ($urandom_range(0, 1) == 1);
      d  = $urandom_range(0, 11);
      ng = !dv && ($urandom_range(0, 7) == 0);
      en = ($urandom_range(0, 19) == 0);
      cl = ($urandom_range(0, 59) == 0);
      ak = ($urandom_range(0, 3) == 0);
      drive(dv, d, ng, en, cl, ak);
      rdy = !m_done && m_pend == 0 && !en && !cl;
      #1;
      chk($sformatf("rnd%0d.ready", i), int'(dig_ready), int'(rdy));
      @(posedge clk);
      #1;
      model_step(dv, d, ng, en, cl, ak);
      check_out($sformatf("rnd%0d", i), m_acc, m_sg, m_cnt, m_done, m_pend > 0, m_err);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dec_entry_14b.md
# dec_entry_14b

Digit-serial decimal-to-binary entry block: accepts BCD digits one at a time over a valid/ready handshake and accumulates them into a 14-bit binary magnitude plus sign. It is the input-side counterpart of the 14-bit binary-to-BCD display path: keypad/switch digits come in, and a binary operand goes out to the multiplier datapath and the display. Each digit costs one shift-add multiply-by-10 sequence, and the result is held until the consumer acknowledges it.

## Interface
- NDIG, 4: maximum digits per entry; must satisfy 10^NDIG - 1 < 2^W
- W, 14: accumulator/result width
- clk  in  1  system clock, all state updates on posedge
- clr_n  in  1  asynchronous active-low reset
- dig  in  4  BCD digit; legal values 0..9
- dig_valid  in  1  digit present on dig
- dig_ready  out  1  block can accept a digit; accept = dig_valid & dig_ready
- neg  in  1  one-cycle pulse, toggles sign during entry
- enter  in  1  one-cycle pulse, finalize entry
- clear  in  1  synchronous clear, highest priority after reset
- result_ack  in  1  consumer acknowledges held result
- value  out  W  running/final magnitude (accumulator)
- sign  out  1  1 = negative
- digit_cnt  out  3  digits accepted so far, 0..NDIG
- busy  out  1  high in MUL and ADD
- result_valid  out  1  high in DONE
- err  out  1  one-cycle pulse on a rejected digit

## Operation
- States: ENTRY, MUL, ADD, DONE. Reset state is ENTRY.
- dig_ready = (state==ENTRY) & ~enter & ~clear (combinational).
- ENTRY, accepted digit, dig<=9, digit_cnt<NDIG:
  - latch digit; go to MUL.
- MUL:
  - tmp <= (acc<<3) + digit, computed in W+4 bits; go to ADD.
- ADD:
  - acc <= truncate_W(tmp + (acc<<1)); digit_cnt += 1; go to ENTRY.
- ENTRY, accepted digit with dig>9 or digit_cnt==NDIG:
  - digit is consumed and discarded; err=1 for the next cycle; acc, cnt and state are unchanged.
- ENTRY, neg: sign <= ~sign. neg is ignored in every other state.
- ENTRY, enter: go to DONE. If acc==0, force sign <= 0 (no negative zero). enter with digit_cnt==0 is legal and gives result 0.
- DONE:
  - value and sign are frozen; dig_ready=0; digits, neg and enter are ignored.
  - On result_ack: acc<=0, digit_cnt<=0, sign<=0, go to ENTRY.
- clear (any state): acc<=0, digit_cnt<=0, sign<=0, err<=0, state<=ENTRY. It discards an in-flight MUL/ADD digit.
- Priority: clr_n > clear > enter > digit > neg. An enter and a neg in the same ENTRY cycle: the sign toggles first, then the zero-sign rule is applied.
- Overflow cannot occur when NDIG/W obey the parameter rule; no saturation logic is required.

## Timing
- Reset (clr_n low) asynchronously forces:
  - state=ENTRY; value=0, sign=0, digit_cnt=0, busy=0, result_valid=0, err=0.
  - dig_ready=1 once clr_n is high.
- A digit accepted at edge k:
  - MUL after k, ADD after k+1.
  - value and digit_cnt update at edge k+2; ready is high again after k+2.
  - Next accept is possible at edge k+3, i.e. a peak rate of one digit per 3 cycles.
- busy is high exactly for the 2 cycles between edges k and k+2.
- value tracks acc live during entry, so the display shows partial entries.
- enter at edge e: result_valid=1 from e until the edge that samples result_ack; it drops the cycle after.
- err: registered, asserted for exactly 1 cycle following the rejecting edge.
- clr_n deasserted mid-sequence: the block resumes in ENTRY with everything zero; no partial digit survives.

## Test plan
- Digits 1,2,3,4 then enter -> value=1234 (0x04D2), sign=0, digit_cnt=4, result_valid=1 held until result_ack, then all zero and dig_ready=1.
- Digit 0xB after entering 7 -> err pulses 1 cycle, value stays 7, digit_cnt stays 1.
- Digits 9,9,9,9 then a fifth digit 5 -> value=9999 (0x270F), err pulse, digit_cnt=4; enter gives 9999.
- neg, digits 4,2, enter -> value=42, sign=1. neg then enter with no digits -> value=0, sign=0.
- Assert clear in the cycle after accepting digit 3 (state MUL) with acc=12 -> value=0, digit_cnt=0, state ENTRY; the next digit 5 gives value=5.
- dig_valid held high with dig=6 across acceptance: exactly one accept per 3 cycles; 3 accepts give value=666. Pulse clr_n low mid-ADD -> all outputs 0 immediately.
